instr_fetch_unit: RTL and testbench

//  Instruction-side producer for the RV32 core. Fetches words from instruction memory and hands
//  {pc, instr} to decode (opcode bits [6:0] feed the main control decoder). Handles in-order

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 fetch-side definitions: opcode constants, fetch queue entry, fetch FSM states.
package riscv_pkg;

    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic is_legal_op(input logic [6:0] op);
        return op inside {OP_NOP, OP_LOAD, OP_STORE, OP_RTYPE,
                          OP_BRANCH, OP_ITYPE, OP_JAL, OP_LUI};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue between instruction memory responses and decode; flush empties it in one cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [AW:0]  o_count,
    output logic         o_empty
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    fetch_entry_t r_mem [FIFO_DEPTH];
    logic [AW:0]  r_wr_ptr, r_rd_ptr;
    logic         w_full, w_push, w_pop;

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (o_count == '0);
    assign w_full  = (o_count == DEPTH_C);
    assign w_pop   = i_pop & ~o_empty & ~i_flush;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign w_push  = i_push & ~i_flush & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_flush && w_full && !w_pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 instruction fetch: credit-limited requests, in-order responses, redirect flush/drain.
// Optional opcode legality flag enabled by defining ILLEGAL_OP_CHECK_EN.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_illegal,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

    fetch_state_e  r_state, w_state_nxt;
    logic [31:0]   r_fetch_pc, r_rsp_pc, w_redirect_pc;
    logic [AW:0]   r_outstanding, r_discard, w_out_nxt, w_disc_nxt, w_count;
    logic [AW+1:0] w_reserved;
    logic          w_empty, w_accept, w_push, w_pop, w_drop;
    fetch_entry_t  w_head, w_push_entry;

    assign w_redirect_pc = redirect_pc & ~32'h3;
    assign w_pop         = id_ready & ~w_empty & ~redirect_valid;

    // Every in-flight request owns a queue slot; the head leaving this cycle frees its slot now,
    // which is what lets a zero-wait memory stream one instruction per cycle.
    assign w_reserved     = {1'b0, r_outstanding} + {1'b0, w_count} - (AW+2)'(w_pop);
    assign imem_req_valid = (r_state == ST_RUN) & ~redirect_valid & (w_reserved < DEPTH_W);
    assign w_accept       = imem_req_valid & imem_req_ready;
    assign w_out_nxt      = r_outstanding + (AW+1)'(w_accept) - (AW+1)'(imem_rsp_valid);

    assign w_drop       = redirect_valid | (r_discard != '0);
    assign w_push       = imem_rsp_valid & ~w_drop;
    assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};

    always_comb begin
        w_state_nxt = r_state;
        w_disc_nxt  = r_discard;
        unique case (r_state)
            ST_BOOT:  w_state_nxt = ST_RUN;
            ST_RUN:   if (redirect_valid && (w_out_nxt != '0)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!redirect_valid && (r_discard == '0)) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_BOOT;
        endcase
        // No requests issue while draining, so after a redirect every request still in flight is stale.
        if (redirect_valid)
            w_disc_nxt = w_out_nxt;
        else if (imem_rsp_valid && (r_discard != '0))
            w_disc_nxt = r_discard - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_out_nxt;
            r_discard     <= w_disc_nxt;
            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)   r_rsp_pc   <= r_rsp_pc + 32'd4;
            end
        end
    end

    fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign imem_req_addr = r_fetch_pc;
    assign id_valid      = ~w_empty;
    assign id_pc         = w_head.pc;
    assign id_instr      = w_head.instr;

`ifdef ILLEGAL_OP_CHECK_EN
    assign id_illegal = ~w_empty & ~is_legal_op(w_head.instr[6:0]);
`else
    assign id_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based memory and sequential-PC decode model.
module tb_instr_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        id_valid, id_ready = 1'b0, id_illegal;
    logic [31:0] id_instr, id_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_illegal(id_illegal), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; bit dropped; } mreq_t;
    mreq_t       pending[$];
    logic [31:0] m_fetch, m_dec;
    int          checks = 0, errors = 0, delivered = 0;
    bit          mem_hold = 0;
    int          mem_wait_pct = 0;

    bit          s_req, s_idv, s_ill, s_drain, fire_req, fire_id, e_ill;
    logic [31:0] s_addr, s_pc, s_instr, e_addr, e_pc, e_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        logic [31:0] h;
        logic [6:0]  op;
        if (pc == 32'h300) return 32'h0000_0017;
        if (pc == 32'h304) return 32'h0000_0033;
        h  = pc * 32'h9E37_79B1;
        op = 7'h33;
        case (pc[4:2])
            3'd0: op = pc[5] ? 7'h7F : 7'h33;
            3'd1: op = 7'h03;
            3'd2: op = 7'h23;
            3'd3: op = 7'h63;
            3'd4: op = 7'h13;
            3'd5: op = 7'h6F;
            3'd6: op = 7'h37;
            default: op = 7'h17;
        endcase
        return {h[31:7] ^ {18'b0, h[6:0]}, op};
    endfunction

    function automatic bit legal_ref(input logic [6:0] op);
        return op == 7'h00 || op == 7'h03 || op == 7'h23 || op == 7'h33 ||
               op == 7'h63 || op == 7'h13 || op == 7'h6F || op == 7'h37;
    endfunction

    // One clock cycle: memory model drives a response, outputs sampled at negedge, model advanced.
    task automatic step(input bit rdy, input bit idr, input bit redir, input logic [31:0] rpc);
        mreq_t r;
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pending.size() > 0 && !mem_hold && $urandom_range(0, 99) >= mem_wait_pct) begin
            r = pending.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(r.addr);
        end
        s_drain = 0;
        foreach (pending[i]) if (pending[i].dropped) s_drain = 1;
        @(negedge clk);
        s_req = imem_req_valid; s_addr = imem_req_addr;
        s_idv = id_valid; s_pc = id_pc; s_instr = id_instr; s_ill = id_illegal;
        e_addr  = m_fetch;
        e_pc    = m_dec;
        e_instr = instr_of(m_dec);
`ifdef ILLEGAL_OP_CHECK_EN
        e_ill = s_idv && !legal_ref(e_instr[6:0]);
`else
        e_ill = 1'b0;
`endif
        fire_req = s_req && rdy;
        fire_id  = s_idv && idr && !redir;
        @(posedge clk);
        #1;
        if (redir) begin
            foreach (pending[i]) pending[i].dropped = 1;
            m_fetch = rpc & ~32'h3;
            m_dec   = rpc & ~32'h3;
        end else if (fire_id) begin
            m_dec = m_dec + 32'd4;
            delivered++;
        end
        if (fire_req) begin
            r.addr = s_addr; r.dropped = 0;
            pending.push_back(r);
            if (!redir) m_fetch = m_fetch + 32'd4;
        end
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        imem_req_ready = 0; id_ready = 0; redirect_valid = 0; redirect_pc = '0;
        imem_rsp_valid = 0; imem_rsp_data = '0;
        pending.delete();
        m_fetch = RPC; m_dec = RPC;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        hold_reset();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
        checks++; if (imem_req_addr !== RPC) begin errors++; $display("FAIL rst_req_addr got %h exp %h", imem_req_addr, RPC); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
        checks++; if (id_pc !== 32'h0 || id_instr !== 32'h0) begin errors++; $display("FAIL rst_id_data got %h/%h exp 0/0", id_pc, id_instr); end
        checks++; if (id_illegal !== 1'b0) begin errors++; $display("FAIL rst_id_illegal got %b exp 0", id_illegal); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        mem_wait_pct = 0; mem_hold = 0;
        for (int k = 1; k <= 14; k++) begin
            step(1, 1, 0, '0);
            if (k == 1) begin checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", s_req); end end
            if (k == 2) begin checks++; if (s_req !== 1'b1 || s_addr !== RPC) begin errors++; $display("FAIL first_req got %b/%h exp 1/%h", s_req, s_addr, RPC); end end
            if (k == 3) begin checks++; if (s_idv !== 1'b0) begin errors++; $display("FAIL id_latency got %b exp 0", s_idv); end end
            if (k >= 4) begin
                checks++;
                if (s_idv !== 1'b1 || s_pc !== 32'((k - 4) * 4))
                    begin errors++; $display("FAIL stream_pc got %b/%h exp 1/%h", s_idv, s_pc, 32'((k - 4) * 4)); end
            end
            if (fire_req) begin checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL stream_addr got %h exp %h", s_addr, e_addr); end end
            if (fire_id) begin checks++; if (s_instr !== e_instr) begin errors++; $display("FAIL stream_instr got %h exp %h", s_instr, e_instr); end end
        end
    endtask

    task automatic test_backpressure();
        for (int k = 1; k <= 6; k++) begin
            step(1, 0, 0, '0);
            if (k >= 5) begin
                checks++;
                if (s_req !== 1'b0 || s_idv !== 1'b1) begin errors++; $display("FAIL bp_credit got req=%b idv=%b exp req=0 idv=1", s_req, s_idv); end
            end
            if (fire_req) begin checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL bp_addr got %h exp %h", s_addr, e_addr); end end
        end
        for (int k = 1; k <= 10; k++) begin
            step(1, 1, 0, '0);
            if (fire_req) begin checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL bp_resume_addr got %h exp %h", s_addr, e_addr); end end
            if (fire_id) begin
                checks++;
                if (s_pc !== e_pc || s_instr !== e_instr) begin errors++; $display("FAIL bp_resume_id got %h/%h exp %h/%h", s_pc, s_instr, e_pc, e_instr); end
            end
        end
    endtask

    task automatic test_redirect();
        int          n;
        bit          seen;
        logic [31:0] first_pc;
        mem_hold = 1; n = 0;
        while (pending.size() < DEPTH && n < 10) begin step(1, 1, 0, '0); n++; end
        checks++; if (pending.size() != DEPTH) begin errors++; $display("FAIL rd_outstanding got %0d exp %0d", pending.size(), DEPTH); end
        step(1, 1, 0, '0);
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rd_credit_req got %b exp 0", s_req); end
        step(1, 1, 1, 32'h100);
        mem_hold = 0; mem_wait_pct = 0; seen = 0; first_pc = '0;
        for (int k = 0; k < 14; k++) begin
            step(1, 1, 0, '0);
            if (s_drain) begin checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rd_drain_req got %b exp 0", s_req); end end
            if (fire_req) begin checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL rd_addr got %h exp %h", s_addr, e_addr); end end
            if (fire_id) begin
                if (!seen) begin seen = 1; first_pc = s_pc; end
                checks++;
                if (s_pc !== e_pc || s_instr !== e_instr) begin errors++; $display("FAIL rd_id got %h/%h exp %h/%h", s_pc, s_instr, e_pc, e_instr); end
            end
        end
        checks++; if (!seen || first_pc !== 32'h100) begin errors++; $display("FAIL rd_first_pc got %h seen=%b exp 00000100", first_pc, seen); end
    endtask

    task automatic test_unaligned();
        int pend_before;
        mem_wait_pct = 0;
        repeat (3) step(1, 1, 0, '0);
        pend_before = pending.size();
        step(1, 1, 1, 32'h203);
        checks++; if (pend_before == 0 || imem_rsp_valid !== 1'b1) begin errors++; $display("FAIL ua_rsp_collide got pend=%0d rsp=%b exp >0/1", pend_before, imem_rsp_valid); end
        step(1, 1, 0, '0);
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin errors++; $display("FAIL ua_addr got %b/%h exp 1/00000200", s_req, s_addr); end
        for (int k = 0; k < 8; k++) begin
            step(1, 1, 0, '0);
            if (fire_id) begin
                checks++;
                if (s_pc !== e_pc || s_instr !== e_instr) begin errors++; $display("FAIL ua_id got %h/%h exp %h/%h", s_pc, s_instr, e_pc, e_instr); end
            end
        end
    endtask

    task automatic test_wrap();
        bit seen_zero = 0;
        step(1, 1, 1, 32'hFFFF_FFF8);
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 0, '0);
            if (fire_req) begin
                if (s_addr === 32'h0) seen_zero = 1;
                checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL wrap_addr got %h exp %h", s_addr, e_addr); end
            end
            if (fire_id) begin
                checks++;
                if (s_pc !== e_pc || s_instr !== e_instr) begin errors++; $display("FAIL wrap_id got %h/%h exp %h/%h", s_pc, s_instr, e_pc, e_instr); end
            end
        end
        checks++; if (!seen_zero) begin errors++; $display("FAIL wrap_zero got none exp addr 00000000 accepted"); end
    endtask

    task automatic test_illegal();
        bit exp17, seen17 = 0, seen33 = 0;
`ifdef ILLEGAL_OP_CHECK_EN
        exp17 = 1'b1;
`else
        exp17 = 1'b0;
`endif
        step(1, 1, 1, 32'h300);
        for (int k = 0; k < 8; k++) begin
            step(1, 1, 0, '0);
            if (s_idv && s_pc === 32'h300) begin
                seen17 = 1; checks++;
                if (s_instr !== 32'h17 || s_ill !== exp17) begin errors++; $display("FAIL ill_auipc got %h/%b exp 00000017/%b", s_instr, s_ill, exp17); end
            end
            if (s_idv && s_pc === 32'h304) begin
                seen33 = 1; checks++;
                if (s_instr !== 32'h33 || s_ill !== 1'b0) begin errors++; $display("FAIL ill_rtype got %h/%b exp 00000033/0", s_instr, s_ill); end
            end
        end
        checks++; if (!seen17 || !seen33) begin errors++; $display("FAIL ill_seen got %b%b exp 11", seen17, seen33); end
    endtask

    task automatic test_random();
        int          start = delivered;
        logic [31:0] rpc;
        bit          redir;
        mem_wait_pct = 40;
        for (int k = 0; k < 2500; k++) begin
            redir = ($urandom_range(0, 99) < 3);
            rpc   = $urandom();
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, redir, rpc);
            if (redir) begin checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rnd_redir_req got %b exp 0", s_req); end end
            if (s_drain) begin checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rnd_drain_req got %b exp 0", s_req); end end
            if (fire_req) begin checks++; if (s_addr !== e_addr) begin errors++; $display("FAIL rnd_addr got %h exp %h", s_addr, e_addr); end end
            if (fire_id) begin
                checks++;
                if (s_pc !== e_pc || s_instr !== e_instr) begin errors++; $display("FAIL rnd_id got %h/%h exp %h/%h", s_pc, s_instr, e_pc, e_instr); end
            end
            if (s_idv) begin checks++; if (s_ill !== e_ill) begin errors++; $display("FAIL rnd_illegal got %b exp %b", s_ill, e_ill); end end
            if (pending.size() > DEPTH) begin checks++; errors++; $display("FAIL rnd_credit got %0d exp <=%0d", pending.size(), DEPTH); end
        end
        checks++; if (delivered - start < 200) begin errors++; $display("FAIL rnd_progress got %0d exp >=200", delivered - start); end
    endtask

    task automatic test_reset_mid();
        mem_wait_pct = 0;
        repeat (5) step(1, 1, 0, '0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || imem_req_addr !== RPC)
            begin errors++; $display("FAIL mid_reset got req=%b idv=%b addr=%h exp 0/0/%h", imem_req_valid, id_valid, imem_req_addr, RPC); end
        hold_reset();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1, 1, 0, '0);
            if (k == 4) begin checks++; if (s_idv !== 1'b1 || s_pc !== RPC) begin errors++; $display("FAIL mid_restart got %b/%h exp 1/%h", s_idv, s_pc, RPC); end end
            if (fire_id) begin
                checks++;
                if (s_pc !== e_pc || s_instr !== e_instr) begin errors++; $display("FAIL mid_id got %h/%h exp %h/%h", s_pc, s_instr, e_pc, e_instr); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_unaligned();
        test_wrap();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
